// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// ram_access_arbiter : two-client round-robin arbiter for a simple dual-port RAM
// Rev 1.0
// ============================================================================
module ram_access_arbiter #(
  parameter int RAM_WIDTH = 16,
  parameter int ADDR_LINE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_wr_req,
  input  logic [ADDR_LINE-1:0] a_wr_addr,
  input  logic [RAM_WIDTH-1:0] a_wr_data,
  output logic                 a_wr_gnt,
  input  logic                 b_wr_req,
  input  logic [ADDR_LINE-1:0] b_wr_addr,
  input  logic [RAM_WIDTH-1:0] b_wr_data,
  output logic                 b_wr_gnt,
  input  logic                 a_rd_req,
  input  logic [ADDR_LINE-1:0] a_rd_addr,
  output logic                 a_rd_gnt,
  output logic                 a_rd_valid,
  input  logic                 b_rd_req,
  input  logic [ADDR_LINE-1:0] b_rd_addr,
  output logic                 b_rd_gnt,
  output logic                 b_rd_valid,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 ram_wr_en,
  output logic [ADDR_LINE-1:0] ram_wr_addr,
  output logic [RAM_WIDTH-1:0] ram_wr_data,
  output logic                 ram_rd_en,
  output logic [ADDR_LINE-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_rd_data
);

  localparam logic c_CLIENT_A = 1'b0;
  localparam logic c_CLIENT_B = 1'b1;

  logic r_wr_ptr;
  logic r_rd_ptr;
  logic r_rd_owner;
  logic r_rd_pending;

  logic                 w_a_wr_req;
  logic                 w_b_wr_req;
  logic                 w_a_rd_req;
  logic                 w_b_rd_req;
  logic                 w_rd_cand_a;
  logic                 w_rd_cand_b;
  logic [ADDR_LINE-1:0] w_rd_cand_addr;
  logic                 w_hazard;

  // Requests are masked while reset is held so every grant reads zero.
  assign w_a_wr_req = a_wr_req & rst_n;
  assign w_b_wr_req = b_wr_req & rst_n;
  assign w_a_rd_req = a_rd_req & rst_n;
  assign w_b_rd_req = b_rd_req & rst_n;

  always_comb begin
    a_wr_gnt    = w_a_wr_req & (~w_b_wr_req | (r_wr_ptr == c_CLIENT_A));
    b_wr_gnt    = w_b_wr_req & (~w_a_wr_req | (r_wr_ptr == c_CLIENT_B));
    ram_wr_en   = a_wr_gnt | b_wr_gnt;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (a_wr_gnt) begin
      ram_wr_addr = a_wr_addr;
      ram_wr_data = a_wr_data;
    end else if (b_wr_gnt) begin
      ram_wr_addr = b_wr_addr;
      ram_wr_data = b_wr_data;
    end
  end

  // The read candidate is blocked (not replaced) when it collides with the
  // write issued in the same cycle; the RAM would otherwise return stale data.
  always_comb begin
    w_rd_cand_a    = w_a_rd_req & (~w_b_rd_req | (r_rd_ptr == c_CLIENT_A));
    w_rd_cand_b    = w_b_rd_req & (~w_a_rd_req | (r_rd_ptr == c_CLIENT_B));
    w_rd_cand_addr = w_rd_cand_a ? a_rd_addr : b_rd_addr;
    w_hazard       = ram_wr_en & (w_rd_cand_a | w_rd_cand_b) &
                     (w_rd_cand_addr == ram_wr_addr);
    a_rd_gnt       = w_rd_cand_a & ~w_hazard;
    b_rd_gnt       = w_rd_cand_b & ~w_hazard;
    ram_rd_en      = a_rd_gnt | b_rd_gnt;
    ram_rd_addr    = ram_rd_en ? w_rd_cand_addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= c_CLIENT_A;
      r_rd_ptr     <= c_CLIENT_A;
      r_rd_owner   <= c_CLIENT_A;
      r_rd_pending <= 1'b0;
    end else begin
      if (a_wr_gnt) begin
        r_wr_ptr <= c_CLIENT_B;
      end else if (b_wr_gnt) begin
        r_wr_ptr <= c_CLIENT_A;
      end
      if (a_rd_gnt) begin
        r_rd_ptr   <= c_CLIENT_B;
        r_rd_owner <= c_CLIENT_A;
      end else if (b_rd_gnt) begin
        r_rd_ptr   <= c_CLIENT_A;
        r_rd_owner <= c_CLIENT_B;
      end
      r_rd_pending <= ram_rd_en;
    end
  end

  assign a_rd_valid = r_rd_pending & (r_rd_owner == c_CLIENT_A);
  assign b_rd_valid = r_rd_pending & (r_rd_owner == c_CLIENT_B);
  assign rd_data    = ram_rd_data;

endmodule
`default_nettype wire
